ex_mem_flag_reg: RTL and testbench
==================================

# ex_mem_flag_reg

EX/MEM pipeline boundary for the 16-bit core: registers the ALU result and the memory/writeback control of the instruction leaving execute. Owns the architectural N/Z/V flag register, updated per opcode class. Sits directly downstream of the ALU. Feeds the memory stage and the branch-condition logic in decode.

## Interface
Parameters:
- DATA_W, 16, datapath width
- RD_W, 4, destination register index width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all EX/MEM state this cycle
- flush  in  1  turn the captured instruction into a bubble
- ex_valid  in  1  execute-stage instruction is real
- ex_is_alu  in  1  instruction is an ALU opcode (op field meaningful for flags)
- ex_op  in  3  ALU op: 0 ADD, 1 SUB, 2 RED, 3 XOR, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB
- ex_alu_out  in  DATA_W  ALU result
- ex_flag  in  3  ALU adder flags {N,Z,V}
- ex_rd  in  RD_W  destination register
- ex_reg_wen, ex_mem_wen, ex_mem_ren  in  1 each  control
- ex_store_data  in  DATA_W  store data
- mem_valid  out  1  registered valid
- mem_alu_out, mem_store_data  out  DATA_W  registered data
- mem_rd  out  RD_W  registered destination
- mem_reg_wen, mem_mem_wen, mem_mem_ren  out  1 each  registered control
- flag_out  out  3  architectural {N,Z,V}

## Operation
- Capture condition: `cap = !rst & !flush & !stall`. When cap is high, all mem_* take ex_* values and mem_valid is set to ex_valid.
- Flush, when rst is low: mem_valid, mem_reg_wen, mem_mem_wen and mem_mem_ren clear to 0. Data fields and mem_rd hold. Flush overrides stall.
- Stall, when flush and rst are low: every register holds, including flag_out.
- Flag update occurs only when cap & ex_valid & ex_is_alu:
  - op 0/1 (ADD/SUB): flag ← ex_flag (N, Z and V all written).
  - op 3–6 (XOR/SLL/SRA/ROR): only Z is written, Z ← (ex_alu_out == 0). N and V hold.
  - op 2/7 (RED/PADDSB): no flag change.
- Non-ALU instructions (ex_is_alu=0) and bubbles (ex_valid=0) never modify flags.
- No width conversion: values pass through unchanged. The Z compare covers all DATA_W bits.

## Timing
- Reset (sync): all mem_* outputs become 0 on the next edge, and flag_out becomes 3'b000. Reset wins over flush and stall.
- Latency: 1 cycle, ex_* to mem_*.
- Flags are registered: flag_out reflects an instruction's update on the cycle after capture.
- Stall is sampled per cycle. A stall of N cycles holds the outputs for N cycles, and the instruction on ex_* must stay stable until it is captured.
- Flush and stall asserted together: bubble inserted, no flag update.
- Reset mid-stall: the next edge clears everything. Stall has no effect on reset.
- Back-to-back flag writers: each captured instruction updates in order. There is no combining.

## Configuration
- EX_FLAG_BYPASS_EN defined:
  - flag_out is combinational.
  - When a flag update occurs this cycle, flag_out shows the value about to be written, with per-bit masking per the op class.
  - Otherwise flag_out shows the register.
  - This lets a branch in decode, directly behind an ALU op, resolve without a bubble.
- Not defined: flag_out is the register output only. The hazard unit must insert one bubble between a flag writer and a dependent branch.

## Test plan
- Reset then idle: rst=1 for one edge → all mem_* = 0 and flag_out = 000. Outputs stay 0 with ex_valid=0.
- ADD capture: ex_op=0, ex_alu_out=16'h8000, ex_flag=3'b101, ex_rd=3, ex_reg_wen=1 → next cycle mem_alu_out=16'h8000, mem_rd=3, mem_reg_wen=1, flag_out=101.
- Z-only update: after flag=101, XOR with ex_alu_out=0 → flag_out=111. Then SLL with result 16'h0004 → flag_out=101.
- No-update ops: PADDSB and RED with ex_flag=3'b010 leave flag_out unchanged. An ex_is_alu=0 load leaves flags unchanged.
- Stall/flush: stall=1 for 3 cycles holds all outputs and flags. Stall=1 with flush=1 → mem_valid=0, all wens 0, flags unchanged, mem_alu_out held.
- Bypass:
  - With EX_FLAG_BYPASS_EN, SUB with ex_flag=001 makes flag_out=001 in the same cycle.
  - Without the macro, flag_out=001 appears only after the edge.

Source files
------------

// File: rtl/ex_mem_flag_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_reg
//
// EX/MEM pipeline boundary for the 16-bit core. Registers the ALU result, the
// store data, the destination index and the memory/writeback control of the
// instruction leaving execute. Also owns the architectural {N,Z,V} flag
// register, which is updated per ALU opcode class.
//
// Configuration macro:
//   EX_FLAG_BYPASS_EN  defined   -> flag_out is combinational. It shows the
//                                   value being written this cycle, or the
//                                   register when there is no update.
//                      undefined -> flag_out is the flag register only.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   stall                    hold all EX/MEM state this cycle
//   flush                    turn the captured instruction into a bubble
//   ex_valid, ex_is_alu      execute-stage qualifiers
//   ex_op[2:0]               0 ADD,1 SUB,2 RED,3 XOR,4 SLL,5 SRA,6 ROR,7 PADDSB
//   ex_alu_out, ex_flag      ALU result and adder flags {N,Z,V}
//   ex_rd, ex_reg_wen,
//   ex_mem_wen, ex_mem_ren,
//   ex_store_data            destination, control and store data
//   mem_*                    registered copies of the ex_* fields
//   flag_out[2:0]            architectural {N,Z,V}
// ---------------------------------------------------------------------------
module ex_mem_flag_reg #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_is_alu,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [2:0]        ex_flag,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_wen,
  input  logic              ex_mem_wen,
  input  logic              ex_mem_ren,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_reg_wen,
  output logic              mem_mem_wen,
  output logic              mem_mem_ren,
  output logic [2:0]        flag_out
);

  logic              cap;
  logic              valid_reg;
  logic [DATA_W-1:0] alu_out_reg;
  logic [DATA_W-1:0] store_data_reg;
  logic [RD_W-1:0]   rd_reg;
  logic              reg_wen_reg;
  logic              mem_wen_reg;
  logic              mem_ren_reg;

  logic [2:0]        flag_reg;
  logic [2:0]        flag_next;
  logic [2:0]        flag_wmask;
  logic [2:0]        flag_wval;
  logic              result_zero;

  assign cap         = !rst && !flush && !stall;
  assign result_zero = (ex_alu_out == '0);

  // Pipeline register. Flush only kills the qualifiers; the data fields keep
  // their old contents since nothing downstream looks at them in a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      alu_out_reg    <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      reg_wen_reg    <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_ren_reg    <= 1'b0;
    end else if (flush) begin
      valid_reg   <= 1'b0;
      reg_wen_reg <= 1'b0;
      mem_wen_reg <= 1'b0;
      mem_ren_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg      <= ex_valid;
      alu_out_reg    <= ex_alu_out;
      store_data_reg <= ex_store_data;
      rd_reg         <= ex_rd;
      reg_wen_reg    <= ex_reg_wen;
      mem_wen_reg    <= ex_mem_wen;
      mem_ren_reg    <= ex_mem_ren;
    end
  end

  // Per-bit write mask for the flag register, decoded from the op class.
  // The mask is all-zero unless a real ALU instruction is captured this cycle.
  always_comb begin
    flag_wmask = 3'b000;
    flag_wval  = ex_flag;
    if (cap && ex_valid && ex_is_alu) begin
      case (ex_op)
        3'd0, 3'd1: begin
          flag_wmask = 3'b111;
          flag_wval  = ex_flag;
        end
        3'd3, 3'd4, 3'd5, 3'd6: begin
          // Logic/shift ops: only Z is meaningful, derived from the result.
          flag_wmask = 3'b010;
          flag_wval  = {1'b0, result_zero, 1'b0};
        end
        default: begin
          flag_wmask = 3'b000;
          flag_wval  = ex_flag;
        end
      endcase
    end
  end

  // Merge new bits into the held flags; unmasked bits keep the register value,
  // so flag_next equals flag_reg whenever there is no update.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag_bit
      assign flag_next[gi] = flag_wmask[gi] ? flag_wval[gi] : flag_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg <= 3'b000;
    end else begin
      flag_reg <= flag_next;
    end
  end

`ifdef EX_FLAG_BYPASS_EN
  // Forward the in-flight update so a branch right behind an ALU op resolves
  // without a bubble.
  assign flag_out = flag_next;
`else
  assign flag_out = flag_reg;
`endif

  assign mem_valid      = valid_reg;
  assign mem_alu_out    = alu_out_reg;
  assign mem_store_data = store_data_reg;
  assign mem_rd         = rd_reg;
  assign mem_reg_wen    = reg_wen_reg;
  assign mem_mem_wen    = mem_wen_reg;
  assign mem_mem_ren    = mem_ren_reg;

endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_flag_reg
//
// Directed bench for ex_mem_flag_reg. Inputs change 1 time unit after a rising
// edge and outputs are checked 1 time unit after the following rising edge.
// Flags are written {N,Z,V}.
// ---------------------------------------------------------------------------
module tb_ex_mem_flag_reg;

  localparam int DATA_W = 16;
  localparam int RD_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic              ex_is_alu;
  logic [2:0]        ex_op;
  logic [DATA_W-1:0] ex_alu_out;
  logic [2:0]        ex_flag;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_reg_wen;
  logic              ex_mem_wen;
  logic              ex_mem_ren;
  logic [DATA_W-1:0] ex_store_data;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_out;
  logic [DATA_W-1:0] mem_store_data;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_reg_wen;
  logic              mem_mem_wen;
  logic              mem_mem_ren;
  logic [2:0]        flag_out;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ex_mem_flag_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_is_alu     (ex_is_alu),
    .ex_op         (ex_op),
    .ex_alu_out    (ex_alu_out),
    .ex_flag       (ex_flag),
    .ex_rd         (ex_rd),
    .ex_reg_wen    (ex_reg_wen),
    .ex_mem_wen    (ex_mem_wen),
    .ex_mem_ren    (ex_mem_ren),
    .ex_store_data (ex_store_data),
    .mem_valid     (mem_valid),
    .mem_alu_out   (mem_alu_out),
    .mem_store_data(mem_store_data),
    .mem_rd        (mem_rd),
    .mem_reg_wen   (mem_reg_wen),
    .mem_mem_wen   (mem_mem_wen),
    .mem_mem_ren   (mem_mem_ren),
    .flag_out      (flag_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check every registered output against one expected set.
  task automatic chk_all(input string tag, input logic v, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [3:0] rd,
                         input logic rw, input logic mw, input logic mr,
                         input logic [2:0] fl);
    chk({tag, ".valid"}, {15'd0, mem_valid}, {15'd0, v});
    chk({tag, ".alu"},   mem_alu_out, alu);
    chk({tag, ".sdata"}, mem_store_data, sd);
    chk({tag, ".rd"},    {12'd0, mem_rd}, {12'd0, rd});
    chk({tag, ".rwen"},  {15'd0, mem_reg_wen}, {15'd0, rw});
    chk({tag, ".mwen"},  {15'd0, mem_mem_wen}, {15'd0, mw});
    chk({tag, ".mren"},  {15'd0, mem_mem_ren}, {15'd0, mr});
    chk({tag, ".flag"},  {13'd0, flag_out}, {13'd0, fl});
    $display("step %-10s valid=%0d alu=%h rd=%0d rwen=%0d mwen=%0d mren=%0d flag=%b",
             tag, mem_valid, mem_alu_out, mem_rd, mem_reg_wen, mem_mem_wen,
             mem_mem_ren, flag_out);
  endtask

  task automatic drive(input logic v, input logic alu_i, input logic [2:0] op,
                       input logic [15:0] alu, input logic [2:0] fl,
                       input logic [3:0] rd, input logic rw, input logic mw,
                       input logic mr, input logic [15:0] sd);
    ex_valid      = v;
    ex_is_alu     = alu_i;
    ex_op         = op;
    ex_alu_out    = alu;
    ex_flag       = fl;
    ex_rd         = rd;
    ex_reg_wen    = rw;
    ex_mem_wen    = mw;
    ex_mem_ren    = mr;
    ex_store_data = sd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flag(input string tag, input logic [2:0] fl);
    chk(tag, {13'd0, flag_out}, {13'd0, fl});
    $display("step %-10s flag=%b", tag, flag_out);
  endtask

  initial begin
    // Reset with a live ALU instruction, stall and flush all asserted: reset wins.
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    drive(1, 1, 3'd0, 16'hFFFF, 3'b111, 4'hF, 1, 1, 1, 16'hFFFF);
    @(posedge clk); #1;
    step();
    chk_all("reset", 0, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b000);

    // Idle bubble.
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 3'd0, 16'h0000, 3'b000, 4'd0, 0, 0, 0, 16'h0000);
    step();
    chk_all("idle", 0, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b000);

    // ADD writes all three flags.
    drive(1, 1, 3'd0, 16'h8000, 3'b101, 4'd3, 1, 0, 0, 16'h1234);
    step();
    chk_all("add", 1, 16'h8000, 16'h1234, 4'd3, 1, 0, 0, 3'b101);

    // XOR with zero result sets Z only; N,V hold even though ex_flag is 000.
    drive(1, 1, 3'd3, 16'h0000, 3'b000, 4'd4, 1, 0, 0, 16'h0000);
    step();
    chk_flag("xor_z", 3'b111);

    // SLL with nonzero result clears Z only.
    drive(1, 1, 3'd4, 16'h0004, 3'b111, 4'd4, 1, 0, 0, 16'h0000);
    step();
    chk_flag("sll_nz", 3'b101);

    // PADDSB and RED never touch flags.
    drive(1, 1, 3'd7, 16'h0000, 3'b010, 4'd1, 1, 0, 0, 16'h0000);
    step();
    chk_flag("paddsb", 3'b101);
    drive(1, 1, 3'd2, 16'h0000, 3'b010, 4'd1, 1, 0, 0, 16'h0000);
    step();
    chk_flag("red", 3'b101);

    // Non-ALU load with ADD-looking op: flags unchanged.
    drive(1, 0, 3'd0, 16'h0040, 3'b010, 4'd5, 1, 0, 1, 16'h5555);
    step();
    chk_all("load", 1, 16'h0040, 16'h5555, 4'd5, 1, 0, 1, 3'b101);

    // Three-cycle stall: everything holds.
    stall = 1'b1;
    drive(1, 1, 3'd0, 16'hBEEF, 3'b000, 4'd7, 0, 1, 0, 16'hCAFE);
    step();
    chk_all("stall1", 1, 16'h0040, 16'h5555, 4'd5, 1, 0, 1, 3'b101);
    step();
    chk_all("stall2", 1, 16'h0040, 16'h5555, 4'd5, 1, 0, 1, 3'b101);
    step();
    chk_all("stall3", 1, 16'h0040, 16'h5555, 4'd5, 1, 0, 1, 3'b101);
    stall = 1'b0;
    step();
    chk_all("unstall", 1, 16'hBEEF, 16'hCAFE, 4'd7, 0, 1, 0, 3'b000);

    // Stall and flush together: bubble, data held, no flag write.
    stall = 1'b1; flush = 1'b1;
    drive(1, 1, 3'd0, 16'h1111, 3'b110, 4'd9, 1, 1, 1, 16'h2222);
    step();
    chk_all("stflush", 0, 16'hBEEF, 16'hCAFE, 4'd7, 0, 0, 0, 3'b000);

    // Flush alone on a zero-result XOR: no Z write.
    stall = 1'b0;
    drive(1, 1, 3'd3, 16'h0000, 3'b000, 4'd2, 1, 0, 0, 16'h0000);
    step();
    chk_all("flush", 0, 16'hBEEF, 16'hCAFE, 4'd7, 0, 0, 0, 3'b000);
    flush = 1'b0;

    // SUB: same-cycle flag visibility depends on the bypass build.
    drive(1, 1, 3'd1, 16'h0001, 3'b001, 4'd6, 1, 0, 0, 16'h0000);
    #1;
`ifdef EX_FLAG_BYPASS_EN
    chk_flag("sub_pre", 3'b001);
`else
    chk_flag("sub_pre", 3'b000);
`endif
    step();
    chk_flag("sub_post", 3'b001);

    // ROR zero result sets Z; SRA with only bit 15 set must clear it again.
    drive(1, 1, 3'd6, 16'h0000, 3'b100, 4'd6, 1, 0, 0, 16'h0000);
    step();
    chk_flag("ror_z", 3'b011);
    drive(1, 1, 3'd5, 16'h8000, 3'b110, 4'd6, 1, 0, 0, 16'h0000);
    step();
    chk_flag("sra_msb", 3'b001);

    // Bubble carrying ADD fields never writes flags.
    drive(0, 1, 3'd0, 16'h0000, 3'b110, 4'd6, 0, 0, 0, 16'h0000);
    step();
    chk_flag("bubble", 3'b001);

    // Reset in the middle of a stall clears everything.
    drive(1, 1, 3'd0, 16'h3333, 3'b110, 4'd8, 1, 0, 0, 16'h4444);
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    chk_all("rst_stall", 0, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
